rgb_to_grayscale: RTL and testbench
===================================

// Module: rgb_to_grayscale
// PURPOSE
// - Converts a stream of 8-bit RGB pixels to 8-bit grayscale using the luma weights 0.299/0.587/0.114, scaled to 77/150/29 (sum 256).
// - Sits at the front of the Sobel chain and feeds the edge kernel.
// - It is the inverse-direction partner of grayscale_to_rgb, which expands the result back to RGB for display.
// - Uses the same done_i/done_o per-pixel valid convention.
// - Also counts pixels and flags the last pixel of each frame.
// PARAMETERS
// - DATA_W  8    channel and grayscale width
// - IMG_W   3    pixels per line
// - IMG_H   3    lines per frame; frame size N = IMG_W*IMG_H
// - W_R     77   red weight
// - W_G     150  green weight
// - W_B     29   blue weight; W_R+W_G+W_B must equal 256 (elaboration-time check)
// - CNT_W   $clog2(IMG_W*IMG_H)  pixel counter width
// PORTS
// - clk           in   1       clock; all logic samples on the rising edge
// - rst           in   1       asynchronous, active-high reset
// - red_i         in   DATA_W  red channel
// - green_i       in   DATA_W  green channel
// - blue_i        in   DATA_W  blue channel
// - done_i        in   1       input pixel valid; one pixel is accepted per cycle while high
// - grayscale_o   out  DATA_W  grayscale result
// - done_o        out  1       grayscale_o valid this cycle
// - frame_done_o  out  1       one-cycle pulse, coincident with done_o, on pixel N of the frame
// - pixel_cnt_o   out  CNT_W   number of pixels accepted in the current frame (0..N-1)
// BEHAVIOUR
// - Reset: every pipeline register, grayscale_o, done_o, frame_done_o and pixel_cnt_o go to 0 immediately.
//   Reset mid-frame discards all in-flight pixels; no done_o is produced for them.
// - Pipeline is 3 registered stages; latency is exactly 3 cycles from done_i to done_o. No backpressure.
//   S1: register pR=red_i*W_R, pG=green_i*W_G, pB=blue_i*W_B (16 bits each), plus v1=done_i and last1.
//   S2: register sum=pR+pG+pB (+ rounding term, see CONFIGURATION) as 16 bits unsigned, plus v2 and last2.
//   S3: grayscale_o <= sum[15:8] when v2; done_o <= v2; frame_done_o <= v2 & last2.
// - Width rule: maximum sum is 255*256+128 = 65408 < 2^16, so there is no overflow and no saturation is needed.
// - Data registers load only when their valid bit is set; otherwise they hold.
//   grayscale_o holds its last value while done_o is low.
// - Bubbles: any done_i pattern reappears on done_o unchanged, delayed by 3 cycles.
// - Frame counter, accept side:
//   On done_i, last1 <= (pixel_cnt_o == N-1).
//   pixel_cnt_o increments on each accepted pixel and wraps from N-1 to 0 on the same edge.
//   The counter holds when done_i is low.
// - Frames are back-to-back capable: pixel 1 of the next frame may follow pixel N on the very next cycle.
// - N==1 is legal: every pixel then pulses frame_done_o and pixel_cnt_o stays at 0.
// CONFIGURATION
// - GRAY_ROUND_EN defined: S2 adds 128 to the sum, giving round-to-nearest.
// - GRAY_ROUND_EN undefined: no rounding term; the result truncates (floor).
// - Latency, ports and counter behaviour are identical in both builds.
// TESTING
// 1. Hold rst=1 with random inputs -> all outputs 0. Release rst -> outputs stay 0 until 3 cycles after the first done_i.
// 2. R=G=B=100, one cycle of done_i -> 3 cycles later done_o=1 and grayscale_o=100, in both builds.
// 3. R=255, G=0, B=0 -> grayscale_o=76 without GRAY_ROUND_EN, 77 with it.
//    R=G=B=255 -> grayscale_o=255 in both builds.
// 4. Nine back-to-back pixels, R=G=B=i for i=1..9, with IMG_W=IMG_H=3:
//    - grayscale_o = 1..9 on consecutive cycles 3..11 after the first done_i
//    - frame_done_o high only with value 9
//    - pixel_cnt_o returns to 0 after the ninth pixel
// 5. done_i pattern 1,0,0,1,1,0,1 -> done_o shows the same pattern 3 cycles later; grayscale_o holds through the gaps.
// 6. Assert rst after pixel 5 of a frame -> no done_o for the in-flight pixels, pixel_cnt_o=0.
//    A new 9-pixel frame then pulses frame_done_o only on its ninth pixel.

Source files
------------

// File: rtl/rgb_to_grayscale.sv
// rgb_to_grayscale: 3-stage pipelined RGB -> 8-bit luma converter.
// gray = (77*R + 150*G + 29*B) >> 8. The weights sum to 256, so the
// shift is exactly 8 bits.
// Optional feature: define GRAY_ROUND_EN to add a +128 rounding term in
// stage 2, which gives round-to-nearest. Without it the result truncates
// (floor). Latency, ports and counter behaviour are the same in both builds.
// The module also counts accepted pixels and marks the last pixel of each
// IMG_W*IMG_H frame.
module rgb_to_grayscale #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 3,
  parameter int IMG_H  = 3,
  parameter int W_R    = 77,
  parameter int W_G    = 150,
  parameter int W_B    = 29,
  // A one-pixel frame still needs a 1-bit port, so the width never drops to 0.
  parameter int CNT_W  = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] red_i,
  input  logic [DATA_W-1:0] green_i,
  input  logic [DATA_W-1:0] blue_i,
  input  logic              done_i,
  output logic [DATA_W-1:0] grayscale_o,
  output logic              done_o,
  output logic              frame_done_o,
  output logic [CNT_W-1:0]  pixel_cnt_o
);

  localparam int N      = IMG_W * IMG_H;
  localparam int FRAC_W = 8;                // weights are scaled to 2^8
  localparam int PROD_W = DATA_W + FRAC_W;  // 255*256+128 still fits, no saturation
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

`ifdef GRAY_ROUND_EN
  localparam logic [PROD_W-1:0] ROUND = PROD_W'(1) << (FRAC_W - 1);
`else
  localparam logic [PROD_W-1:0] ROUND = '0;
`endif

  // Elaboration-time guard: the fixed >>8 is only a correct scale when the weights sum to 256.
  if (W_R + W_G + W_B != 256) begin : g_weight_check
    $error("rgb_to_grayscale: W_R + W_G + W_B must equal 256");
  end

  logic [PROD_W-1:0] p_r, p_g, p_b;
  logic              v1, last1;
  logic [PROD_W-1:0] sum;
  logic              v2, last2;

  // Stage 1: weight each channel and capture the valid bit and the frame-end flag.
  // NOTE: sequential state uses non-blocking (<=) so that every stage samples
  // the previous stage's value from before the edge, not one just written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data registers are reset as well as the valid bits, so
      // grayscale_o reads as 0 after reset and not as stale data.
      p_r   <= '0;
      p_g   <= '0;
      p_b   <= '0;
      v1    <= 1'b0;
      last1 <= 1'b0;
    end else begin
      v1 <= done_i;
      if (done_i) begin
        p_r   <= PROD_W'(red_i)   * PROD_W'(W_R);
        p_g   <= PROD_W'(green_i) * PROD_W'(W_G);
        p_b   <= PROD_W'(blue_i)  * PROD_W'(W_B);
        last1 <= (pixel_cnt_o == LAST_IDX);
      end
    end
  end

  // Accept-side pixel counter: it advances once per accepted pixel and wraps on the frame's last pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_cnt_o <= '0;
    end else if (done_i) begin
      pixel_cnt_o <= (pixel_cnt_o == LAST_IDX) ? '0 : pixel_cnt_o + CNT_W'(1);
    end
  end

  // Stage 2: add the three weighted channels and the optional rounding term.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum   <= '0;
      v2    <= 1'b0;
      last2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        sum   <= p_r + p_g + p_b + ROUND;
        last2 <= last1;
      end
    end
  end

  // Stage 3: take the integer part of the sum; grayscale_o holds its value while no pixel is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grayscale_o  <= '0;
      done_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      done_o       <= v2;
      frame_done_o <= v2 & last2;
      if (v2) grayscale_o <= sum[PROD_W-1:FRAC_W];
    end
  end

endmodule

// File: tb/tb_rgb_to_grayscale.sv
// tb_rgb_to_grayscale: self-checking bench for rgb_to_grayscale.
// A reference model computes luma with plain integer arithmetic and keeps a
// 3-deep queue of expected outputs. Directed tests run first, then a random
// stream of pixels and bubbles.
module tb_rgb_to_grayscale;

  localparam int N = 9;
`ifdef GRAY_ROUND_EN
  localparam int RND = 128;
`else
  localparam int RND = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] red_i, green_i, blue_i;
  logic       done_i;
  logic [7:0] grayscale_o;
  logic       done_o, frame_done_o;
  logic [3:0] pixel_cnt_o;

  rgb_to_grayscale dut (
    .clk          (clk),
    .rst          (rst),
    .red_i        (red_i),
    .green_i      (green_i),
    .blue_i       (blue_i),
    .done_i       (done_i),
    .grayscale_o  (grayscale_o),
    .done_o       (done_o),
    .frame_done_o (frame_done_o),
    .pixel_cnt_o  (pixel_cnt_o)
  );

  // 10 ns free-running clock.
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit v;
    bit fd;
    int gray;
  } exp_t;

  exp_t pipe[$];
  int   acc_cnt;
  int   exp_gray;
  bit   exp_done, exp_fd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int luma(input int r, input int g, input int b);
    return (77 * r + 150 * g + 29 * b + RND) / 256;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".done"},  done_o,       exp_done);
    check({tag, ".gray"},  grayscale_o,  exp_gray);
    check({tag, ".fdone"}, frame_done_o, exp_fd);
    check({tag, ".cnt"},   pixel_cnt_o,  acc_cnt);
  endtask

  // Apply one cycle of input, advance the model, then compare just after the edge.
  task automatic step(input int r, input int g, input int b, input bit d, input string tag);
    exp_t e;
    red_i   = 8'(r);
    green_i = 8'(g);
    blue_i  = 8'(b);
    done_i  = d;
    e.v    = d;
    e.gray = luma(r, g, b);
    e.fd   = d && (acc_cnt == N - 1);
    if (d) acc_cnt = (acc_cnt + 1) % N;
    pipe.push_back(e);
    @(posedge clk);
    #1;
    if (pipe.size() == 3) begin
      e        = pipe.pop_front();
      exp_done = e.v;
      exp_fd   = e.fd;
      if (e.v) exp_gray = e.gray;
    end
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1'b0, tag);
  endtask

  // Assert reset asynchronously with random inputs, confirm the outputs clear, then release it.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    pipe.delete();
    acc_cnt  = 0;
    exp_gray = 0;
    exp_done = 1'b0;
    exp_fd   = 1'b0;
    #1;
    check_outputs({tag, ".async"});
    for (int i = 0; i < 2; i++) begin
      red_i   = 8'($urandom);
      green_i = 8'($urandom);
      blue_i  = 8'($urandom);
      done_i  = 1'($urandom);
      @(posedge clk);
      #1;
      check_outputs({tag, ".hold"});
    end
    done_i = 1'b0;
    rst    = 1'b0;
  endtask

  initial begin
    bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int exp_red;
    rst     = 1'b1;
    red_i   = '0;
    green_i = '0;
    blue_i  = '0;
    done_i  = 1'b0;

    // 1. Reset with random inputs, then stay quiet until the first pixel emerges.
    do_reset("rst0");
    idle(3, "post_rst");

    // 2. A mid-grey pixel must come out unchanged.
    step(100, 100, 100, 1'b1, "grey100");
    idle(2, "grey100");
    check("grey100.lit", grayscale_o, 100);

    // 3. Pure red shows the truncate/round difference; white must saturate to 255 exactly.
`ifdef GRAY_ROUND_EN
    exp_red = 77;
`else
    exp_red = 76;
`endif
    step(255, 0, 0, 1'b1, "red");
    idle(2, "red");
    check("red.lit", grayscale_o, exp_red);
    step(255, 255, 255, 1'b1, "white");
    idle(2, "white");
    check("white.lit", grayscale_o, 255);

    // 4. A full back-to-back frame from a clean counter.
    do_reset("rst1");
    for (int i = 1; i <= 9; i++) step(i, i, i, 1'b1, "frame9");
    idle(3, "frame9_tail");
    check("frame9.cnt_wrap", pixel_cnt_o, 0);

    // 5. A bubble pattern must reappear delayed by 3 cycles, with gray held through the gaps.
    for (int i = 0; i < 7; i++)
      step($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), pat[i], "bubbles");
    idle(3, "bubbles_tail");

    // 6. Reset mid-frame after pixel 5 discards in-flight pixels; a new frame then ends only on its 9th pixel.
    do_reset("rst2");
    for (int i = 0; i < 5; i++) step(20 * i, 10 * i, 5 * i, 1'b1, "partial");
    do_reset("rst_mid");
    idle(3, "after_mid");
    for (int i = 0; i < 9; i++) step(30 + i, 60 + i, 90 + i, 1'b1, "frame_after");
    idle(3, "frame_after_tail");

    // 7. A random stream of pixels and bubbles spanning many frames.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
           ($urandom_range(0, 9) < 7), "rand");
    idle(3, "rand_tail");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
